// File: rtl/spi_ready_scheduler.sv
// Cluster scheduler for the SPI trace uplink: raises DataReady to the host on fill
// threshold, accumulation timeout or overflow, and paces clusters with a holdoff gap.
module spi_ready_scheduler #(
    parameter int BUFFLENLOG2 = 9,
    parameter int TIMEOUT_W   = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Enable,
    input  logic [BUFFLENLOG2-1:0] FramesCnt,
    input  logic                   Transmitting,
    input  logic                   Overflow,
    input  logic [BUFFLENLOG2-1:0] Threshold,
    input  logic [TIMEOUT_W-1:0]   Timeout,
    input  logic [7:0]             Holdoff,
    output logic                   DataReady,
    output logic                   Urgent,
    output logic [15:0]            ClusterCount,
    output logic [15:0]            TimeoutCount,
    output logic [2:0]             State
);

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_EMPTY    = 3'd1,
        ST_ACCUM    = 3'd2,
        ST_READY    = 3'd3,
        ST_BUSY     = 3'd4,
        ST_HOLDOFF  = 3'd5
    } state_t;

    state_t                 state;
    state_t                 stateNext;
    logic [TIMEOUT_W-1:0]   timer;
    logic [TIMEOUT_W-1:0]   timerNext;
    logic [7:0]             holdCnt;
    logic [7:0]             holdNext;
    logic                   urgentReg;
    logic                   urgentNext;
    logic                   clusterInc;
    logic                   timeoutInc;
    logic [15:0]            clusterCnt;
    logic [15:0]            timeoutCnt;

    // Transmitting is sampled into txSample, and edges are taken against the copy
    // one clock older, so a level change sampled at edge N acts at edge N+1.
    logic                   txSample;
    logic                   txPrev;
    logic                   txRise;
    logic                   txFall;

    logic [BUFFLENLOG2-1:0] effThreshold;
    logic                   thresholdMet;
    logic                   frameAvail;

    assign txRise       = txSample & ~txPrev;
    assign txFall       = ~txSample & txPrev;
    assign effThreshold = (Threshold == '0) ? BUFFLENLOG2'(1) : Threshold;
    assign thresholdMet = (FramesCnt >= effThreshold);
    assign frameAvail   = (FramesCnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_DISABLED;
            timer      <= '0;
            holdCnt    <= '0;
            urgentReg  <= 1'b0;
            clusterCnt <= '0;
            timeoutCnt <= '0;
            txSample   <= 1'b0;
            txPrev     <= 1'b0;
        end else begin
            state     <= stateNext;
            timer     <= timerNext;
            holdCnt   <= holdNext;
            urgentReg <= urgentNext;
            txSample  <= Transmitting;
            txPrev    <= txSample;
            if (clusterInc) begin
                clusterCnt <= clusterCnt + 16'd1;
            end
            if (timeoutInc && (timeoutCnt != 16'hFFFF)) begin
                timeoutCnt <= timeoutCnt + 16'd1;
            end
        end
    end

    always_comb begin
        stateNext  = state;
        timerNext  = timer;
        holdNext   = holdCnt;
        urgentNext = urgentReg;
        clusterInc = 1'b0;
        timeoutInc = 1'b0;

        if (Overflow && (state != ST_DISABLED)) begin
            urgentNext = 1'b1;
        end

        if (!Enable && (state != ST_BUSY)) begin
            stateNext = ST_DISABLED;
        end else begin
            case (state)
                ST_DISABLED: begin
                    stateNext = ST_EMPTY;
                end

                ST_EMPTY: begin
                    if (txRise) begin
                        stateNext  = ST_BUSY;
                        clusterInc = 1'b1;
                        urgentNext = 1'b0;
                    end else if (frameAvail) begin
                        stateNext = ST_ACCUM;
                        timerNext = Timeout;
                    end
                end

                ST_ACCUM: begin
                    if (txRise) begin
                        stateNext  = ST_BUSY;
                        clusterInc = 1'b1;
                        urgentNext = 1'b0;
                    end else if (!frameAvail) begin
                        stateNext = ST_EMPTY;
                    end else if (urgentReg || thresholdMet) begin
                        stateNext = ST_READY;
                    end else if ((Timeout != '0) && (timer == TIMEOUT_W'(1))) begin
                        stateNext  = ST_READY;
                        timeoutInc = 1'b1;
                    end else if (timer != '0) begin
                        timerNext = timer - TIMEOUT_W'(1);
                    end
                end

                ST_READY: begin
                    if (txRise) begin
                        stateNext  = ST_BUSY;
                        clusterInc = 1'b1;
                        urgentNext = 1'b0;
                    end
                end

                ST_BUSY: begin
                    // A disable during a cluster only takes effect once the sender lets go.
                    if (txFall) begin
                        if (!Enable) begin
                            stateNext = ST_DISABLED;
                        end else if (Holdoff != 8'd0) begin
                            stateNext = ST_HOLDOFF;
                            holdNext  = Holdoff;
                        end else if (frameAvail) begin
                            stateNext = ST_ACCUM;
                            timerNext = Timeout;
                        end else begin
                            stateNext = ST_EMPTY;
                        end
                    end
                end

                ST_HOLDOFF: begin
                    if (holdCnt != 8'd0) begin
                        holdNext = holdCnt - 8'd1;
                    end
                    if (txRise) begin
                        stateNext  = ST_BUSY;
                        clusterInc = 1'b1;
                        urgentNext = 1'b0;
                    end else if (holdCnt == 8'd1) begin
                        if (frameAvail) begin
                            stateNext = ST_ACCUM;
                            timerNext = Timeout;
                        end else begin
                            stateNext = ST_EMPTY;
                        end
                    end
                end

                default: begin
                    stateNext = ST_DISABLED;
                end
            endcase
        end
    end

    assign DataReady    = (state == ST_READY);
    assign Urgent       = urgentReg;
    assign ClusterCount = clusterCnt;
    assign TimeoutCount = timeoutCnt;
    assign State        = state;

endmodule

// File: tb/tb_spi_ready_scheduler.sv
// Directed bench for spi_ready_scheduler: threshold, timeout, overflow, holdoff,
// disable mid-cluster and asynchronous reset, with hand-computed expectations.
module tb_spi_ready_scheduler;

    localparam int BUFFLENLOG2 = 9;
    localparam int TIMEOUT_W   = 24;

    logic                   clk;
    logic                   rst;
    logic                   enable;
    logic [BUFFLENLOG2-1:0] frames_cnt;
    logic                   transmitting;
    logic                   overflow;
    logic [BUFFLENLOG2-1:0] threshold;
    logic [TIMEOUT_W-1:0]   timeout;
    logic [7:0]             holdoff;
    logic                   data_ready;
    logic                   urgent;
    logic [15:0]            cluster_count;
    logic [15:0]            timeout_count;
    logic [2:0]             state;

    int checks;
    int failures;

    spi_ready_scheduler #(
        .BUFFLENLOG2(BUFFLENLOG2),
        .TIMEOUT_W  (TIMEOUT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Enable      (enable),
        .FramesCnt   (frames_cnt),
        .Transmitting(transmitting),
        .Overflow    (overflow),
        .Threshold   (threshold),
        .Timeout     (timeout),
        .Holdoff     (holdoff),
        .DataReady   (data_ready),
        .Urgent      (urgent),
        .ClusterCount(cluster_count),
        .TimeoutCount(timeout_count),
        .State       (state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // one active edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        enable       = 1'b0;
        frames_cnt   = '0;
        transmitting = 1'b0;
        overflow     = 1'b0;
        threshold    = 9'd4;
        timeout      = '0;
        holdoff      = 8'd0;
        #1;
        check_eq("reset_state", 32'(state), 0);
        check_eq("reset_ready", 32'(data_ready), 0);
        check_eq("reset_urgent", 32'(urgent), 0);
        check_eq("reset_ccount", 32'(cluster_count), 0);
        check_eq("reset_tcount", 32'(timeout_count), 0);
        #1;
        rst = 1'b0;

        // threshold and poll
        enable = 1'b1;
        tick();
        check_eq("en_to_empty", 32'(state), 1);
        frames_cnt = 9'd3;
        tick();
        check_eq("accum_entry", 32'(state), 2);
        check_eq("below_thr_a", 32'(data_ready), 0);
        tick();
        check_eq("below_thr_b", 32'(data_ready), 0);
        frames_cnt = 9'd4;
        tick();
        check_eq("thr_ready", 32'(data_ready), 1);
        check_eq("thr_state", 32'(state), 3);
        transmitting = 1'b1;
        tick();
        check_eq("poll_sample", 32'(data_ready), 1);
        tick();
        check_eq("poll_ready_low", 32'(data_ready), 0);
        check_eq("poll_busy", 32'(state), 4);
        check_eq("poll_ccount1", 32'(cluster_count), 1);

        // holdoff
        holdoff      = 8'd5;
        frames_cnt   = 9'd200;
        threshold    = 9'd8;
        transmitting = 1'b0;
        tick();
        check_eq("fall_sample_busy", 32'(state), 4);
        tick();
        check_eq("holdoff_entry", 32'(state), 5);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("holdoff_ready_low", 32'(data_ready), 0);
            check_eq("holdoff_state", 32'(state), 5);
        end
        tick();
        check_eq("holdoff_exit_accum", 32'(state), 2);
        check_eq("holdoff_exit_low", 32'(data_ready), 0);
        tick();
        check_eq("holdoff_reassert", 32'(data_ready), 1);
        transmitting = 1'b1;
        ticks(2);
        check_eq("poll_ccount2", 32'(cluster_count), 2);

        // timeout
        holdoff      = 8'd0;
        frames_cnt   = 9'd1;
        threshold    = 9'd100;
        timeout      = 24'd10;
        transmitting = 1'b0;
        ticks(2);
        check_eq("to_accum_entry", 32'(state), 2);
        for (int i = 1; i < 10; i++) begin
            tick();
            check_eq("to_wait_low", 32'(data_ready), 0);
        end
        tick();
        check_eq("to_ready", 32'(data_ready), 1);
        check_eq("to_tcount", 32'(timeout_count), 1);
        transmitting = 1'b1;
        ticks(2);
        check_eq("poll_ccount3", 32'(cluster_count), 3);

        // disable mid-cluster
        enable     = 1'b0;
        frames_cnt = 9'd300;
        threshold  = 9'd8;
        tick();
        check_eq("dis_busy_a", 32'(state), 4);
        tick();
        check_eq("dis_busy_b", 32'(state), 4);
        transmitting = 1'b0;
        tick();
        check_eq("dis_busy_c", 32'(state), 4);
        tick();
        check_eq("dis_after_fall", 32'(state), 0);
        check_eq("dis_ready_low", 32'(data_ready), 0);
        tick();
        check_eq("dis_stays", 32'(state), 0);
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        check_eq("dis_no_urgent", 32'(urgent), 0);
        transmitting = 1'b1;
        ticks(2);
        check_eq("dis_rise_state", 32'(state), 0);
        check_eq("dis_rise_ccount", 32'(cluster_count), 3);
        transmitting = 1'b0;
        ticks(2);

        // overflow
        enable     = 1'b1;
        frames_cnt = 9'd2;
        threshold  = 9'd50;
        timeout    = '0;
        ticks(3);
        check_eq("ovf_accum", 32'(state), 2);
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        check_eq("ovf_urgent_set", 32'(urgent), 1);
        check_eq("ovf_still_accum", 32'(data_ready), 0);
        tick();
        check_eq("ovf_ready", 32'(data_ready), 1);
        transmitting = 1'b1;
        tick();
        check_eq("ovf_urgent_hold", 32'(urgent), 1);
        tick();
        check_eq("ovf_urgent_clear", 32'(urgent), 0);
        check_eq("poll_ccount4", 32'(cluster_count), 4);

        // async reset while ready
        frames_cnt   = 9'd300;
        threshold    = 9'd8;
        transmitting = 1'b0;
        ticks(3);
        check_eq("pre_rst_ready", 32'(data_ready), 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_ready", 32'(data_ready), 0);
        check_eq("arst_state", 32'(state), 0);
        check_eq("arst_ccount", 32'(cluster_count), 0);
        check_eq("arst_tcount", 32'(timeout_count), 0);
        check_eq("arst_urgent", 32'(urgent), 0);
        rst = 1'b0;
        tick();
        check_eq("arst_restart", 32'(state), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
